// File: rtl/irq_pkg.sv
// Shared constants for the interrupt request unit: source bit indices and register addresses.
// Latency: none (constants only).
// Backpressure: not applicable.
package irq_pkg;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam int IRQ_NSRC = 5;

  localparam logic [15:0] IF_ADDR  = 16'hFF0F;
  localparam logic [15:0] OVR_ADDR = 16'hFF7F;

endpackage

// File: rtl/irq_request_unit_if.sv
// System bus and CPU interrupt handshake between the CPU side and the request unit.
// Latency: wires only; timing is defined by the endpoints.
// Backpressure: none; the CPU holds ack for at least one cycle.
interface irq_request_unit_if;
  logic [15:0] A;
  logic [7:0]  D_in;
  logic [7:0]  D_out;
  logic        RD;
  logic        WR;
  logic [7:0]  CPU_IRQ_TRIG;
  logic [7:0]  CPU_IRQ_ACK;

  // CPU / bus master side
  modport master (
    output A, D_in, RD, WR, CPU_IRQ_ACK,
    input  D_out, CPU_IRQ_TRIG
  );

  // Interrupt request unit side
  modport slave (
    input  A, D_in, RD, WR, CPU_IRQ_ACK,
    output D_out, CPU_IRQ_TRIG
  );
endinterface

// File: rtl/irq_flag_bit.sv
// One interrupt source: event/ack edge detect, IF flag with set>write>clear priority, sticky overrun bit.
// Latency: flag and overrun update on the rising edge that samples the event, write or ack edge.
// Backpressure: none; events arriving while pending are recorded in the overrun bit instead of queued.
module irq_flag_bit (
  input  logic CLK,
  input  logic nRES,
  input  logic evt,
  input  logic ack,
  input  logic wr_en,
  input  logic wr_dat,
  input  logic ovr_clr,
  output logic if_bit,
  output logic ovr_bit
);

  logic evt_q;
  logic ack_q;
  logic set_evt;
  logic clr_evt;
  logic ovr_set;
  logic if_nxt;
  logic ovr_nxt;

  // Edge detection and next-state for the flag and overrun bits
  always_comb begin
    set_evt = evt & ~evt_q;
    clr_evt = ack & ~ack_q;
    // A pending event is lost only if nothing retires the flag this same cycle
    ovr_set = set_evt & if_bit & ~clr_evt & ~(wr_en & ~wr_dat);

    if_nxt = if_bit;
    if (set_evt) begin
      if_nxt = 1'b1;
    end else if (wr_en) begin
      if_nxt = wr_dat;
    end else if (clr_evt) begin
      if_nxt = 1'b0;
    end

    ovr_nxt = ovr_bit;
    if (ovr_set) begin
      ovr_nxt = 1'b1;
    end else if (ovr_clr) begin
      ovr_nxt = 1'b0;
    end
  end

  // State registers; evt_q resets high so sources already asserted at reset release are ignored
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      evt_q   <= 1'b1;
      ack_q   <= 1'b0;
      if_bit  <= 1'b0;
      ovr_bit <= 1'b0;
    end else begin
      evt_q   <= evt;
      ack_q   <= ack;
      if_bit  <= if_nxt;
      ovr_bit <= ovr_nxt;
    end
  end

endmodule

// File: rtl/irq_request_unit.sv
// Interrupt request unit: collects source events into IF (0xFF0F), drives CPU requests, retires on one-hot ack.
// Latency: event/write/ack take effect on the sampling edge; reads are combinational.
// Backpressure: none; overlapping events are flagged in the read-to-clear overrun register (0xFF7F).
module irq_request_unit
  import irq_pkg::*;
(
  input  logic                CLK,
  input  logic                nRES,
  input  logic [IRQ_NSRC-1:0] EVT,
  irq_request_unit_if.slave   bus
);

  logic                if_sel;
  logic                ovr_sel;
  logic                if_wr;
  logic                ovr_rd;
  logic [IRQ_NSRC-1:0] if_reg;
  logic [IRQ_NSRC-1:0] ovr_reg;
  logic                unused_bits;

  assign unused_bits = ^{bus.D_in[7:IRQ_NSRC], bus.CPU_IRQ_ACK[7:IRQ_NSRC]};

  // Address decode for the two mapped registers
  always_comb begin
    if_sel  = (bus.A == IF_ADDR);
    ovr_sel = (bus.A == OVR_ADDR);
    if_wr   = bus.WR & if_sel;
    ovr_rd  = bus.RD & ovr_sel;
  end

  genvar i;
  generate
    for (i = 0; i < IRQ_NSRC; i++) begin : g_src
      irq_flag_bit u_flag (
        .CLK     (CLK),
        .nRES    (nRES),
        .evt     (EVT[i]),
        .ack     (bus.CPU_IRQ_ACK[i]),
        .wr_en   (if_wr),
        .wr_dat  (bus.D_in[i]),
        .ovr_clr (ovr_rd),
        .if_bit  (if_reg[i]),
        .ovr_bit (ovr_reg[i])
      );
    end
  endgenerate

  // Read mux; unmapped or idle reads float high like a precharged bus
  always_comb begin
    bus.D_out = 8'hFF;
    if (bus.RD && if_sel) begin
      bus.D_out = {3'b111, if_reg};
    end else if (bus.RD && ovr_sel) begin
      bus.D_out = {3'b000, ovr_reg};
    end
  end

  // Requests come straight from the IF flops
  assign bus.CPU_IRQ_TRIG = {3'b000, if_reg};

endmodule

// File: tb/tb_irq_request_unit.sv
// Directed self-checking bench for irq_request_unit.
// Latency: inputs driven 2ns after a rising edge, outputs sampled before the next edge.
// Backpressure: not applicable.
module tb_irq_request_unit;

  logic       CLK;
  logic       nRES;
  logic [4:0] EVT;
  int         n_tests;
  int         n_fail;

  irq_request_unit_if bus_if ();

  irq_request_unit dut (
    .CLK  (CLK),
    .nRES (nRES),
    .EVT  (EVT),
    .bus  (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] dat);
    bus_if.A    = addr;
    bus_if.D_in = dat;
    bus_if.WR   = 1'b1;
    step();
    bus_if.WR   = 1'b0;
  endtask

  task automatic bus_read_chk(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    bus_if.A  = addr;
    bus_if.RD = 1'b1;
    #1;
    chk(tag, bus_if.D_out, exp);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    nRES = 1'b0;
    EVT  = 5'b00001;
    bus_if.A = 16'h0000;
    bus_if.D_in = 8'h00;
    bus_if.RD = 1'b0;
    bus_if.WR = 1'b0;
    bus_if.CPU_IRQ_ACK = 8'h00;

    // Reset state
    #1;
    chk("rst_trig", bus_if.CPU_IRQ_TRIG, 8'h00);
    chk("rst_dout", bus_if.D_out, 8'hFF);
    step();
    step();
    nRES = 1'b1;
    step();
    step();
    chk("rel_no_evt", bus_if.CPU_IRQ_TRIG, 8'h00);

    // VBlank edge after release
    EVT = 5'b00000;
    step();
    EVT = 5'b00001;
    step();
    chk("vblank_set", bus_if.CPU_IRQ_TRIG, 8'h01);
    bus_read_chk("rd_if_e1", 16'hFF0F, 8'hE1);
    bus_if.RD = 1'b0;
    #1;
    chk("idle_dout", bus_if.D_out, 8'hFF);

    // Acknowledge held for three cycles
    EVT = 5'b00101;
    step();
    chk("if_05", bus_if.CPU_IRQ_TRIG, 8'h05);
    bus_if.CPU_IRQ_ACK = 8'h04;
    step();
    chk("ack_1", bus_if.CPU_IRQ_TRIG, 8'h01);
    step();
    chk("ack_2", bus_if.CPU_IRQ_TRIG, 8'h01);
    step();
    chk("ack_3", bus_if.CPU_IRQ_TRIG, 8'h01);
    bus_if.CPU_IRQ_ACK = 8'h00;
    step();

    // Set beats clear: re-pend timer, then event and ack rise together
    EVT = 5'b00001;
    step();
    EVT = 5'b00101;
    step();
    chk("timer_repend", bus_if.CPU_IRQ_TRIG, 8'h05);
    EVT = 5'b00001;
    step();
    EVT = 5'b00101;
    bus_if.CPU_IRQ_ACK = 8'h04;
    step();
    chk("set_beats_clr", bus_if.CPU_IRQ_TRIG, 8'h05);
    bus_if.CPU_IRQ_ACK = 8'h00;
    bus_read_chk("ovr_none", 16'hFF7F, 8'h00);
    bus_if.RD = 1'b0;
    EVT = 5'b00001;
    step();

    // Overrun on Joypad
    bus_write(16'hFF0F, 8'h00);
    chk("wr_clear", bus_if.CPU_IRQ_TRIG, 8'h00);
    EVT = 5'b10001;
    step();
    chk("joy_set", bus_if.CPU_IRQ_TRIG, 8'h10);
    EVT = 5'b00001;
    step();
    EVT = 5'b10001;
    step();
    chk("joy_again", bus_if.CPU_IRQ_TRIG, 8'h10);
    bus_read_chk("ovr_rd1", 16'hFF7F, 8'h10);
    step();
    #1;
    chk("ovr_rd2", bus_if.D_out, 8'h00);
    bus_if.RD = 1'b0;

    // CPU writes
    bus_write(16'hFF0F, 8'hFF);
    chk("wr_ff_trig", bus_if.CPU_IRQ_TRIG, 8'h1F);
    bus_read_chk("wr_ff_rd", 16'hFF0F, 8'hFF);
    bus_if.RD = 1'b0;
    EVT = 5'b11001;
    bus_write(16'hFF0F, 8'h00);
    chk("wr0_serial", bus_if.CPU_IRQ_TRIG, 8'h08);
    bus_read_chk("wr0_no_ovr", 16'hFF7F, 8'h00);
    bus_if.RD = 1'b0;

    // Multi-hot ack clears each rising bit
    bus_write(16'hFF0F, 8'h1F);
    bus_if.CPU_IRQ_ACK = 8'h06;
    step();
    chk("multi_ack", bus_if.CPU_IRQ_TRIG, 8'h19);
    bus_if.CPU_IRQ_ACK = 8'h00;

    // Reset mid-cycle
    bus_write(16'hFF0F, 8'h1F);
    chk("pre_rst", bus_if.CPU_IRQ_TRIG, 8'h1F);
    #1;
    nRES = 1'b0;
    #1;
    chk("midrst_trig", bus_if.CPU_IRQ_TRIG, 8'h00);
    bus_read_chk("midrst_if", 16'hFF0F, 8'hE0);
    bus_read_chk("unmapped", 16'hFF00, 8'hFF);
    bus_if.RD = 1'b0;
    step();
    nRES = 1'b1;
    step();
    step();
    chk("post_rst", bus_if.CPU_IRQ_TRIG, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_request_unit.md
# irq_request_unit

Peripheral-side end of the CPU interrupt interface: the unit that produces `CPU_IRQ_TRIG` and consumes `CPU_IRQ_ACK`. It collects event pulses from the five interrupt sources: VBlank, STAT, Timer, Serial and Joypad. It holds them in the IF register at 0xFF0F, which is memory-mapped, and presents them to the CPU core. Pending bits are retired on the CPU's one-hot acknowledge. A sticky overrun register records events lost because their flag was already pending.

## Interface
- `IF_ADDR`, 16'hFF0F, address of the IF register.
- `OVR_ADDR`, 16'hFF7F, address of the overrun register (read-to-clear).
- `CLK  in  1`: single clock; all state updates on its rising edge.
- `nRES  in  1`: reset, asynchronous and active-low.
- `EVT  in  5`: source event levels; bit 0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad.
- `A  in  16`: system address bus.
- `D_in  in  8`: write data.
- `D_out  out  8`: read data.
- `RD  in  1`: read strobe.
- `WR  in  1`: write strobe, one cycle.
- `CPU_IRQ_TRIG  out  8`: request lines to the CPU; [4:0] = IF, [7:5] = 0.
- `CPU_IRQ_ACK  in  8`: acknowledge from the CPU, one-hot, held ≥1 cycle.

## Operation
- **Event edge detect.** Each `EVT[i]` is compared with its registered previous value `evt_q[i]`. `evt_q[i]` = 0 and `EVT[i]` = 1 is a set event for `IF[i]`.
- **Ack edge detect.** Each `CPU_IRQ_ACK[i]` is compared with `ack_q[i]`. A 0→1 transition on bit i is a clear event for `IF[i]`. A held ack clears only once.
- **CPU write.** `WR` with `A == IF_ADDR` loads `IF <= D_in[4:0]`. `D_in[7:5]` is ignored.
- **Per-bit priority in one cycle:** set event, then CPU write, then ack clear. A set event always leaves `IF[i]` = 1, so events are never lost to a simultaneous write or ack.
- **Overrun.**
  - A set event while `IF[i]` is already 1 and no clear or write-to-0 of that bit occurs the same cycle sets `OVR[i]`.
  - `OVR` bits are sticky.
  - A read of `OVR_ADDR` returns `OVR` and clears it at the end of that cycle.
  - A set event in the same cycle as the clearing read re-sets the bit: set wins.
- **Read data** (combinational):
  - `RD` and `A == IF_ADDR`: `{3'b111, IF}`.
  - `RD` and `A == OVR_ADDR`: `{3'b000, OVR}`.
  - Otherwise 8'hFF, matching the precharged-high bus convention.
- **Multi-hot `CPU_IRQ_ACK`** is a protocol violation. Each rising bit still clears its own flag, with no priority resolution here; priority is the CPU's job.

## Timing
- **Reset values:**
  - `IF` = 0, `OVR` = 0, `ack_q` = 0.
  - `evt_q` = 5'b11111, so sources already high at reset release do not generate events.
  - `CPU_IRQ_TRIG` = 0; `D_out` = 8'hFF.
- **Event latency.** Edge sampled at rising edge n sets `IF` at edge n. `CPU_IRQ_TRIG[i]` is high from edge n, since it is driven directly from the `IF` flop.
- **Ack latency.** Ack rising before edge n drops `CPU_IRQ_TRIG[i]` after edge n.
- **Write latency.** Write at edge n is visible on `CPU_IRQ_TRIG` and on read from edge n.
- **Mid-operation reset.** `nRES` assertion immediately forces all reset values, independent of `CLK`. Any in-flight event or ack edge is discarded.

## Structure
- Shared package `irq_pkg`:
  - source bit indices `IRQ_VBLANK`=0, `IRQ_STAT`=1, `IRQ_TIMER`=2, `IRQ_SERIAL`=3, `IRQ_JOYPAD`=4;
  - `IRQ_NSRC`=5;
  - default `IF_ADDR` and `OVR_ADDR`.
- Sub-module `irq_flag_bit`, instantiated ×5. Each instance holds `evt_q`, `ack_q`, the `IF` bit and the `OVR` bit, and applies the priority rules. The top level handles only address decode, read mux and output packing.

## Test plan
- **Reset release.** Release reset with `EVT` = 5'b00001 held high → no `IF` set; `CPU_IRQ_TRIG` = 0. Drop and re-raise `EVT[0]` → `IF` = 0x01 one edge later; read 0xFF0F = 0xE1.
- **Acknowledge.** Pending `IF` = 0x05, pulse `CPU_IRQ_ACK` = 0x04 for 3 cycles → `IF` = 0x01 after the first edge; the held ack causes no further change.
- **Set beats clear.** Timer event and `CPU_IRQ_ACK[2]` rising in the same cycle → `IF[2]` stays 1; `OVR[2]` stays 0 because a clear coincided.
- **Overrun.** With `IF` = 0x10, a second Joypad edge → `OVR` = 0x10. First read of 0xFF7F returns 0x10; second read returns 0x00.
- **CPU write.** Write 0xFF to 0xFF0F → `IF` = 0x1F and `CPU_IRQ_TRIG` = 0x1F. Then write 0x00 simultaneous with a Serial edge → `IF` = 0x08.
- **Reset mid-operation.** Assert `nRES` mid-cycle with `IF` = 0x1F → `CPU_IRQ_TRIG` = 0 immediately. Read of any unmapped address returns 0xFF.
